wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (MA/WB register outputs, after the writeback-data mux) and completed results from the multi-cycle M-extension divide unit. Divide results are held in a 2-entry buffer and drain into idle writeback slots. A starvation counter forces a one-cycle pipeline freeze if a buffered result waits too long. Sits between the MA/WB register, the divider and the register file.

## Interface
- STARVE_LIMIT, 4: cycles a buffered head may wait before a forced stall (1..15).
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- pipe_wen  in  1  pipeline writeback enable (MA/WB regwrite_enable_out).
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  32  pipeline writeback data.
- div_valid  in  1  divider result available.
- div_rd  in  5  divider destination register.
- div_data  in  32  divider result.
- div_ready  out  1  arbiter accepts a divider result this cycle.
- rf_wen  out  1  register-file write enable.
- rf_rd  out  5  register-file write address.
- rf_data  out  32  register-file write data.
- wb_stall  out  1  registered request: freeze MA/WB and upstream for this cycle.

## Operation
- Pipeline slot "live" = pipe_wen=1, pipe_rd≠0, wb_stall=0.
- Buffer: 2 entries {rd, data}, FIFO order, count 0..2.
- div_ready = (count<2) && RESET high; derived only from registered count. No combinational path from div_valid or pipe_*.
- Accept: div_valid && div_ready pushes {div_rd, div_data} at the edge, with these exceptions: div_rd=0 is accepted and discarded; an incoming entry is discarded if a live pipeline write has the same rd in the same cycle.
- Port grant, evaluated combinationally each cycle:
  - live pipeline slot: rf_* = pipe_*.
  - else count>0: rf_* = buffer head; head pops at the edge.
  - else rf_wen=0.
  - rf_rd and rf_data are don't-care when rf_wen=0.
- WAW drop: a live pipeline write invalidates every buffered entry whose rd equals pipe_rd. Removal happens at that edge and the remaining entry compacts to the head. The younger pipeline value wins.
- Starvation counter (4 bits):
  - cleared when count=0 or the head pops.
  - otherwise incremented.
  - when the counter reaches STARVE_LIMIT-1 and the head is not popped this cycle, wb_stall=1 for the next cycle only.
- Stall cycle:
  - pipeline inputs are ignored. Upstream holds MA/WB, so the same write reappears next cycle and is not lost.
  - the head is written and the counter cleared.
  - wb_stall returns to 0 the following cycle.
- Simultaneous push and pop: count unchanged, order preserved (head leaves, new entry enters at tail).
- Push when count=2: cannot occur, because div_ready=0.

## Timing
- Reset (RESET low, asynchronous): count=0, entries invalid, starve counter=0, wb_stall=0, div_ready=0, rf_wen=0. Any buffered result is lost. No write occurs in the first cycle after release.
- Pipeline path: zero latency; rf_* follows pipe_* in the same cycle.
- Divide path: accepted in cycle N gives earliest write in cycle N+1.
- Worst-case wait for a buffered head with continuous live pipeline traffic is STARVE_LIMIT cycles plus the stall cycle. A second entry waits at most a further STARVE_LIMIT+1 cycles.
- wb_stall is never high for two consecutive cycles.
- Pipeline throughput loss: at most 1 cycle per drained starving entry.

## Test plan
- Reset mid-buffer: push two results (rd=5, rd=6) under continuous live pipe writes, then pull RESET low. Required: count=0, wb_stall=0, rf_wen=0 immediately. After release, div_ready=1 and no write of x5/x6 occurs.
- Idle drain: pipe_wen=0, push {rd=3, 0x0000_00AA}. Required: cycle N+1 has rf_wen=1, rf_rd=3, rf_data=0x0000_00AA; div_ready stays 1.
- Starvation with STARVE_LIMIT=4: buffer {rd=7, 0x1234_5678} while a live pipe write occurs every cycle. Required: wb_stall=1 exactly in the 5th cycle after the push. That cycle writes x7. The held pipe write appears again and commits the next cycle.
- Full buffer: push two entries with a live pipe write every cycle. Required: div_ready=0 until the first pop. A push and a pop in the same cycle keep count=2→... both values commit in push order.
- WAW drop: buffer {rd=9, 0x1}, then a live pipe write to rd=9 with 0x2. Required: x9 is written only with 0x2 and the buffer empties. Also, an incoming div_rd=9 in the same cycle as a live pipe rd=9 write is discarded.
- rd=0: a pipe write to rd=0 does not block a buffered head drain. A divider result with rd=0 is accepted and never written.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bundles the writeback port signals: pipeline source, divider source, register-file sink, stall.
// Latency: none, this is wiring only.
// Backpressure: div_ready toward the divider and wb_stall toward the pipeline.
interface wb_port_arbiter_if;
   // pipeline writeback (MA/WB register outputs, after the data mux)
   logic        pipe_wen;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   // divide unit completion
   logic        div_valid;
   logic [4:0]  div_rd;
   logic [31:0] div_data;
   logic        div_ready;
   // register-file write port
   logic        rf_wen;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data;
   // pipeline freeze request
   logic        wb_stall;

   // arbiter side
   modport slave (
      input  pipe_wen, pipe_rd, pipe_data,
      input  div_valid, div_rd, div_data,
      output div_ready,
      output rf_wen, rf_rd, rf_data,
      output wb_stall
   );

   // environment side (pipeline, divider, register file)
   modport master (
      output pipe_wen, pipe_rd, pipe_data,
      output div_valid, div_rd, div_data,
      input  div_ready,
      input  rf_wen, rf_rd, rf_data,
      input  wb_stall
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and a 2-entry divide-result buffer.
// Latency: pipeline writes pass through combinationally; an accepted divide result can write the next cycle.
// Backpressure: div_ready drops when both slots are full; wb_stall freezes the pipeline one cycle for a starving head.
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   wb_port_arbiter_if.slave bus
);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] dat;
   } ent_t;

   // Counter value at which a head that still cannot drain forces a stall next cycle.
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT - 1);

   ent_t       ent0_q, ent1_q;   // ent0 is the head (oldest)
   ent_t       ent0_d, ent1_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] starve_q, starve_d;
   logic       stall_q, stall_d;

   logic       pipe_live;
   logic       buf_rdy;
   logic       head_pop;
   logic       waw0, waw1;
   logic       head_gone;
   logic       keep0, keep1;
   logic       push;
   ent_t       new_ent;

   // A pipeline write only owns the port when it targets a real register and we
   // are not in the forced-drain cycle (MA/WB is held, so it is replayed next cycle).
   assign pipe_live = RESET && bus.pipe_wen && (bus.pipe_rd != 5'd0) && !stall_q;

   // Ready depends only on registered occupancy, never on this cycle's inputs.
   assign buf_rdy   = RESET && (cnt_q != 2'd2);

   // The head drains whenever the pipeline leaves the slot idle.
   assign head_pop  = !pipe_live && (cnt_q != 2'd0);

   // A live pipeline write is younger than anything buffered, so matching entries are stale.
   assign waw0      = pipe_live && (cnt_q != 2'd0) && (ent0_q.rd == bus.pipe_rd);
   assign waw1      = pipe_live && (cnt_q == 2'd2) && (ent1_q.rd == bus.pipe_rd);
   assign head_gone = head_pop || waw0;

   assign keep0     = (cnt_q != 2'd0) && !head_gone;
   assign keep1     = (cnt_q == 2'd2) && !waw1;

   // x0 results and results already superseded by a same-cycle pipeline write are
   // accepted (handshake completes) but never stored.
   assign push      = bus.div_valid && buf_rdy && (bus.div_rd != 5'd0) &&
                      !(pipe_live && (bus.div_rd == bus.pipe_rd));
   assign new_ent   = '{rd: bus.div_rd, dat: bus.div_data};

   // Buffer next state: drop popped/overwritten entries, compact toward the head, append any push.
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      cnt_d  = 2'd0;
      case ({keep0, keep1})
         2'b11:   cnt_d = 2'd2;
         2'b10:   cnt_d = 2'd1;
         2'b01: begin
            ent0_d = ent1_q;
            cnt_d  = 2'd1;
         end
         default: cnt_d = 2'd0;
      endcase
      // A push always finds a free slot: it needs cnt_q < 2 and removal never adds entries.
      if (push) begin
         if (cnt_d == 2'd0) begin
            ent0_d = new_ent;
            cnt_d  = 2'd1;
         end else begin
            ent1_d = new_ent;
            cnt_d  = 2'd2;
         end
      end
   end

   // Starvation tracking: count cycles the current head has waited; request one freeze at the limit.
   always_comb begin
      starve_d = starve_q + 4'd1;
      stall_d  = 1'b0;
      if ((cnt_q == 2'd0) || head_gone) begin
         starve_d = 4'd0;
      end else if (starve_q == STARVE_MAX) begin
         stall_d = 1'b1;
      end
   end

   // State registers; reset discards any buffered results.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ent0_q   <= '0;
         ent1_q   <= '0;
         cnt_q    <= 2'd0;
         starve_q <= 4'd0;
         stall_q  <= 1'b0;
      end else begin
         ent0_q   <= ent0_d;
         ent1_q   <= ent1_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         stall_q  <= stall_d;
      end
   end

   // Port grant: live pipeline first, else buffered head, else idle (address/data zeroed).
   always_comb begin
      bus.rf_wen  = 1'b0;
      bus.rf_rd   = 5'd0;
      bus.rf_data = 32'd0;
      if (pipe_live) begin
         bus.rf_wen  = 1'b1;
         bus.rf_rd   = bus.pipe_rd;
         bus.rf_data = bus.pipe_data;
      end else if (head_pop) begin
         bus.rf_wen  = 1'b1;
         bus.rf_rd   = ent0_q.rd;
         bus.rf_data = ent0_q.dat;
      end
   end

   assign bus.div_ready = buf_rdy;
   assign bus.wb_stall  = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios then randomized traffic against a queue model.
// Latency: outputs sampled on the falling edge; model advances once per rising edge.
// Backpressure: model predicts div_ready and wb_stall from buffer occupancy and head wait time.
module tb_wb_port_arbiter;

   localparam int LIMIT = 4;

   logic CLK;
   logic RESET;

   wb_port_arbiter_if bus ();

   wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] dat;
   } m_ent_t;

   // behavioural model state
   m_ent_t mq[$];
   int     m_starve;
   bit     m_stall;

   int checks;
   int errors;

   // outputs captured in the most recent cycle
   logic        o_wen, o_stall, o_ready;
   logic [4:0]  o_rd;
   logic [31:0] o_dat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit pw, input logic [4:0] prd, input logic [31:0] pdat,
                        input bit dv, input logic [4:0] drd, input logic [31:0] ddat);
      bus.pipe_wen  = pw;
      bus.pipe_rd   = prd;
      bus.pipe_data = pdat;
      bus.div_valid = dv;
      bus.div_rd    = drd;
      bus.div_data  = ddat;
   endtask

   task automatic model_reset();
      mq.delete();
      m_starve = 0;
      m_stall  = 1'b0;
   endtask

   // One clock cycle: check outputs against the model, then advance the model.
   task automatic tick();
      bit          live, popped, gone, stall_n, acc, e_wen;
      logic [4:0]  e_rd;
      logic [31:0] e_dat;
      m_ent_t      e;
      @(negedge CLK);
      o_wen   = bus.rf_wen;
      o_rd    = bus.rf_rd;
      o_dat   = bus.rf_data;
      o_stall = bus.wb_stall;
      o_ready = bus.div_ready;

      live   = bus.pipe_wen && (bus.pipe_rd != 5'd0) && !m_stall;
      popped = 1'b0;
      e_wen  = 1'b0;
      e_rd   = 5'd0;
      e_dat  = 32'd0;
      if (live) begin
         e_wen = 1'b1;
         e_rd  = bus.pipe_rd;
         e_dat = bus.pipe_data;
      end else if (mq.size() != 0) begin
         e_wen  = 1'b1;
         e_rd   = mq[0].rd;
         e_dat  = mq[0].dat;
         popped = 1'b1;
      end

      chk("div_ready", 32'(o_ready), 32'(mq.size() < 2));
      chk("wb_stall", 32'(o_stall), 32'(m_stall));
      chk("rf_wen", 32'(o_wen), 32'(e_wen));
      if (e_wen) begin
         chk("rf_rd", 32'(o_rd), 32'(e_rd));
         chk("rf_data", o_dat, e_dat);
      end

      gone     = popped || (live && mq.size() != 0 && mq[0].rd == bus.pipe_rd);
      stall_n  = (mq.size() != 0) && !gone && (m_starve == LIMIT - 1);
      m_starve = (mq.size() == 0 || gone) ? 0 : m_starve + 1;
      acc      = bus.div_valid && (mq.size() < 2) && (bus.div_rd != 5'd0) &&
                 !(live && bus.div_rd == bus.pipe_rd);
      if (popped) void'(mq.pop_front());
      if (live) begin
         for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rd == bus.pipe_rd) mq.delete(i);
      end
      if (acc) begin
         e.rd  = bus.div_rd;
         e.dat = bus.div_data;
         mq.push_back(e);
      end
      m_stall = stall_n;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      repeat (n) tick();
   endtask

   initial begin
      int busy;
      int pos11, pos12;
      bit found;
      checks = 0;
      errors = 0;
      model_reset();

      // reset state, with a live-looking pipeline write present
      RESET = 1'b1;
      drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 5'd4, 32'h1);
      #1 RESET = 1'b0;
      #2;
      chk("reset_ready", 32'(bus.div_ready), 32'd0);
      chk("reset_stall", 32'(bus.wb_stall), 32'd0);
      chk("reset_wen", 32'(bus.rf_wen), 32'd0);
      @(posedge CLK);
      #2 RESET = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      chk("post_reset_wen", 32'(o_wen), 32'd0);

      // idle drain: result written the cycle after acceptance
      idle(2);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_00AA);
      tick();
      chk("idle_ready_n", 32'(o_ready), 32'd1);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      chk("idle_wen", 32'(o_wen), 32'd1);
      chk("idle_rd", 32'(o_rd), 32'd3);
      chk("idle_data", o_dat, 32'h0000_00AA);
      chk("idle_ready_n1", 32'(o_ready), 32'd1);

      // starvation: stall lands exactly on the 5th cycle after the push
      idle(3);
      drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd7, 32'h1234_5678);
      tick();
      drive(1'b1, 5'd2, 32'hB2, 1'b0, 5'd0, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("starve_no_stall", 32'(o_stall), 32'd0);
         chk("starve_pipe_rd", 32'(o_rd), 32'd2);
      end
      tick();
      chk("starve_stall", 32'(o_stall), 32'd1);
      chk("starve_head_rd", 32'(o_rd), 32'd7);
      chk("starve_head_data", o_dat, 32'h1234_5678);
      tick();
      chk("starve_stall_drop", 32'(o_stall), 32'd0);
      chk("starve_replay_rd", 32'(o_rd), 32'd2);
      chk("starve_replay_data", o_dat, 32'hB2);

      // full buffer under continuous pipeline traffic
      idle(3);
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'hA0A0);
      tick();
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd11, 32'hB0B0);
      tick();
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd12, 32'hC0C0);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         tick();
         if (o_stall) found = 1'b1;
         else chk("full_not_ready", 32'(o_ready), 32'd0);
      end
      chk("full_stall_seen", 32'(found), 32'd1);
      chk("full_first_pop", 32'(o_rd), 32'd10);
      tick();
      chk("full_ready_again", 32'(o_ready), 32'd1);
      drive(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'd0);
      pos11 = -1;
      pos12 = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (o_wen && o_rd == 5'd11 && pos11 < 0) pos11 = i;
         if (o_wen && o_rd == 5'd12 && pos12 < 0) pos12 = i;
      end
      chk("full_push_order", 32'(pos11 >= 0 && pos12 > pos11), 32'd1);

      // WAW: younger pipeline value wins, buffered and incoming x9 both dropped
      idle(3);
      drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h1);
      tick();
      drive(1'b1, 5'd9, 32'h2, 1'b1, 5'd9, 32'h3);
      tick();
      chk("waw_rd", 32'(o_rd), 32'd9);
      chk("waw_data", o_dat, 32'h2);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      chk("waw_empty", 32'(o_wen), 32'd0);

      // rd=0: pipeline x0 does not block the head, divider x0 never written
      idle(3);
      drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
      tick();
      drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
      tick();
      chk("x0_pipe_drain_wen", 32'(o_wen), 32'd1);
      chk("x0_pipe_drain_rd", 32'(o_rd), 32'd4);
      chk("x0_pipe_drain_data", o_dat, 32'h44);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
      tick();
      chk("x0_div_ready", 32'(o_ready), 32'd1);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      chk("x0_div_not_written", 32'(o_wen), 32'd0);

      // reset mid-buffer: two results queued, then asynchronous reset
      idle(3);
      drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd5, 32'h55);
      tick();
      drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66);
      tick();
      drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0);
      #2 RESET = 1'b0;
      #1;
      chk("midrst_ready", 32'(bus.div_ready), 32'd0);
      chk("midrst_stall", 32'(bus.wb_stall), 32'd0);
      chk("midrst_wen", 32'(bus.rf_wen), 32'd0);
      model_reset();
      @(posedge CLK);
      #2 RESET = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      chk("midrst_release_ready", 32'(o_ready), 32'd1);
      chk("midrst_release_wen", 32'(o_wen), 32'd0);
      tick();
      chk("midrst_no_x5_x6", 32'(o_wen), 32'd0);

      // randomized traffic, alternating moderate and heavy pipeline load
      for (int n = 0; n < 3000; n++) begin
         busy = ((n / 500) % 2 == 1) ? 92 : 50;
         drive($urandom_range(0, 99) < busy, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom);
         tick();
      end
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
